// File: rtl/puf_challenge_sequencer.sv
// Initiator for the PDL PUF array: accepts a challenge, runs NUM_EVAL reset/arm/fire/settle/sample
// evaluations against the array, majority-votes each response bit and flags non-unanimous bits.
module puf_challenge_sequencer #(
  parameter int unsigned CHAL_W        = 128,
  parameter int unsigned RESP_W        = 16,
  parameter int unsigned NUM_EVAL      = 5,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned TRIG_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic [RESP_W-1:0] resp_out,
  output logic [RESP_W-1:0] resp_unstable,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_reset,
  output logic              puf_trigger,
  input  logic [RESP_W-1:0] puf_response
);

  localparam int unsigned ONES_W = $clog2(NUM_EVAL + 1);
  localparam int unsigned MAX_AB = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int unsigned MAX_CD = (TRIG_CYCLES > SETTLE_CYCLES) ? TRIG_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    StIdle, StRst, StArm, StFire, StSettle, StSample, StDone
  } state_e;

  state_e                         state;
  logic [CNT_W-1:0]               cnt;
  logic [7:0]                     eval_cnt;
  logic [RESP_W-1:0][ONES_W-1:0]  ones;
  logic [RESP_W-1:0][ONES_W-1:0]  ones_next;
  logic [RESP_W-1:0]              sync1;
  logic [RESP_W-1:0]              sync2;

  // Two-flop synchronizer for the asynchronous PUF outputs, free-running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= puf_response;
      sync2 <= sync1;
    end
  end

  // Per-bit ones count including the evaluation currently being sampled.
  always_comb begin
    ones_next = ones;
    for (int i = 0; i < RESP_W; i++) begin
      ones_next[i] = ones[i] + ONES_W'(sync2[i]);
    end
  end

  // Sequencer FSM; every output is registered and updated on the transition into its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      cnt           <= '0;
      eval_cnt      <= '0;
      ones          <= '0;
      chal_ready    <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_out      <= '0;
      resp_unstable <= '0;
      puf_challenge <= '0;
      puf_reset     <= 1'b1;
      puf_trigger   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (chal_valid) begin
            puf_challenge <= chal_in;
            ones          <= '0;
            eval_cnt      <= '0;
            cnt           <= '0;
            chal_ready    <= 1'b0;
            busy          <= 1'b1;
            puf_reset     <= 1'b1;
            state         <= StRst;
          end
        end
        StRst: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            cnt       <= '0;
            puf_reset <= 1'b0;
            state     <= StArm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StArm: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt         <= '0;
            puf_trigger <= 1'b1;
            state       <= StFire;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StFire: begin
          if (cnt == CNT_W'(TRIG_CYCLES - 1)) begin
            cnt         <= '0;
            puf_trigger <= 1'b0;
            state       <= StSettle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StSettle: begin
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= StSample;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StSample: begin
          ones      <= ones_next;
          eval_cnt  <= eval_cnt + 8'd1;
          puf_reset <= 1'b1;
          if (32'(eval_cnt) + 32'd1 < NUM_EVAL) begin
            state <= StRst;
          end else begin
            // Majority vote: a tie (even NUM_EVAL) resolves to 0.
            for (int i = 0; i < RESP_W; i++) begin
              resp_out[i]      <= ((32'(ones_next[i]) << 1) > NUM_EVAL);
              resp_unstable[i] <= (ones_next[i] != '0) && (32'(ones_next[i]) != NUM_EVAL);
            end
            resp_valid <= 1'b1;
            state      <= StDone;
          end
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            chal_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer: default instance plus a NUM_EVAL=4 instance
// for the tie case. Edge numbers below count the challenge-accept edge as edge 0.
module tb_puf_challenge_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] chal_in;
  logic         chal_valid;
  logic         chal_valid2;
  logic         chal_ready;
  logic [15:0]  resp_out;
  logic [15:0]  resp_unstable;
  logic         resp_valid;
  logic         resp_ready;
  logic         busy;
  logic [127:0] puf_challenge;
  logic         puf_reset;
  logic         puf_trigger;
  logic [15:0]  puf_response;

  logic         chal_ready2;
  logic [15:0]  resp_out2;
  logic [15:0]  resp_unstable2;
  logic         resp_valid2;
  logic         busy2;
  logic [127:0] puf_challenge2;
  logic         puf_reset2;
  logic         puf_trigger2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  puf_challenge_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .chal_in       (chal_in),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .resp_out      (resp_out),
    .resp_unstable (resp_unstable),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .busy          (busy),
    .puf_challenge (puf_challenge),
    .puf_reset     (puf_reset),
    .puf_trigger   (puf_trigger),
    .puf_response  (puf_response)
  );

  puf_challenge_sequencer #(.NUM_EVAL(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .chal_in       (chal_in),
    .chal_valid    (chal_valid2),
    .chal_ready    (chal_ready2),
    .resp_out      (resp_out2),
    .resp_unstable (resp_unstable2),
    .resp_valid    (resp_valid2),
    .resp_ready    (1'b1),
    .busy          (busy2),
    .puf_challenge (puf_challenge2),
    .puf_reset     (puf_reset2),
    .puf_trigger   (puf_trigger2),
    .puf_response  (puf_response)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps edges 1..n after an accept; bit 0 of the response follows seq[eval], eval = edge/27.
  task automatic drive_evals(input logic [4:0] seq, input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k / 27 < 5) puf_response = {15'b0, seq[k / 27]};
    end
  endtask

  int first_valid;
  int rises;
  int run_len;
  logic prev_trig;

  initial begin
    reset        = 1'b1;
    chal_in      = '0;
    chal_valid   = 1'b0;
    chal_valid2  = 1'b0;
    resp_ready   = 1'b0;
    puf_response = '0;
    step();
    step();
    check("rst_chal_ready", chal_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_out", resp_out, 0);
    check("rst_resp_unstable", resp_unstable, 0);
    check("rst_puf_challenge", puf_challenge, 0);
    check("rst_puf_reset", puf_reset, 1);
    check("rst_puf_trigger", puf_trigger, 0);
    reset = 1'b0;
    step();
    check("idle_chal_ready", chal_ready, 1);

    // Stable response, count trigger pulses and result latency; hold resp_ready low.
    puf_response = 16'hA5C3;
    chal_in      = 128'h1;
    chal_valid   = 1'b1;
    step();                                   // edge 0: accept
    chal_valid  = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_chal_ready", chal_ready, 0);
    first_valid = -1;
    rises       = 0;
    run_len     = 0;
    prev_trig   = 1'b0;
    for (int k = 1; k <= 140; k++) begin
      step();
      if (resp_valid && first_valid < 0) first_valid = k;
      if (puf_trigger) begin
        if (!prev_trig) rises++;
        run_len++;
      end else if (prev_trig) begin
        check("trig_width", run_len, 2);
        run_len = 0;
      end
      prev_trig = puf_trigger;
    end
    check("trig_pulses", rises, 5);
    check("first_valid_edge", first_valid, 135);
    check("stable_resp_out", resp_out, 16'hA5C3);
    check("stable_unstable", resp_unstable, 0);
    check("stable_puf_challenge", puf_challenge, 128'h1);

    // Backpressure: result holds, new requests ignored.
    chal_in    = 128'hBEEF;
    chal_valid = 1'b1;
    for (int k = 0; k < 50; k++) step();
    check("bp_resp_valid", resp_valid, 1);
    check("bp_resp_out", resp_out, 16'hA5C3);
    check("bp_chal_ready", chal_ready, 0);
    check("bp_puf_challenge", puf_challenge, 128'h1);
    chal_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    check("bp_release_valid", resp_valid, 0);
    check("bp_release_ready", chal_ready, 1);
    check("bp_release_busy", busy, 0);

    // Noisy bit 0 = 1,0,1,0,1; chal_in changes while busy.
    puf_response = 16'h0001;
    chal_in      = 128'hA;
    chal_valid   = 1'b1;
    step();                                   // edge 0
    chal_valid = 1'b0;
    chal_in    = 128'hB;
    drive_evals(5'b10101, 135);               // ends just after edge 135
    check("noisy1_valid", resp_valid, 1);
    check("noisy1_resp_out", resp_out, 16'h0001);
    check("noisy1_unstable", resp_unstable, 16'h0001);
    check("hold_puf_challenge", puf_challenge, 128'hA);

    // Back-to-back: request held through DONE, accepted in the IDLE cycle right after.
    chal_in      = 128'hC;
    chal_valid   = 1'b1;
    puf_response = 16'h0000;
    step();                                   // edge 136: DONE -> IDLE
    check("b2b_idle_ready", chal_ready, 1);
    check("b2b_idle_valid", resp_valid, 0);
    check("b2b_idle_challenge", puf_challenge, 128'hA);
    chal_valid2 = 1'b1;
    step();                                   // edge 137 = new edge 0
    chal_valid  = 1'b0;
    chal_valid2 = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_puf_challenge", puf_challenge, 128'hC);

    // Noisy bit 0 = 0,1,0,1,0; the 4-eval instance sees 0,1,0,1 (a tie).
    drive_evals(5'b01010, 135);
    check("noisy2_valid", resp_valid, 1);
    check("noisy2_resp_out", resp_out, 0);
    check("noisy2_unstable", resp_unstable, 16'h0001);
    check("tie_resp_out", resp_out2, 0);
    check("tie_unstable", resp_unstable2, 16'h0001);
    check("tie_idle_again", chal_ready2, 1);
    step();

    // Reset in the middle of FIRE.
    chal_in    = 128'h55;
    chal_valid = 1'b1;
    step();                                   // edge 0
    chal_valid = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    check("fire_trigger", puf_trigger, 1);
    reset = 1'b1;
    #1;
    check("midrst_trigger", puf_trigger, 0);
    check("midrst_puf_reset", puf_reset, 1);
    check("midrst_chal_ready", chal_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_challenge", puf_challenge, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("post_rst_idle", busy, 0);
    check("post_rst_no_valid", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
